// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory byte-stream loader.
// Build option: LOADER_CHECKSUM_EN adds the trailing XOR checksum byte and CHK state.
package imem_loader_pkg;

   localparam int unsigned ADDR_W_DFLT    = 8;
   localparam int unsigned MAX_WORDS_DFLT = (2 ** ADDR_W_DFLT) / 4;
   localparam int unsigned WORD_W         = 32;
   localparam int unsigned BYTE_W         = 8;

   // First stream byte of a word is its most significant byte.
   localparam bit LANE_MSB_FIRST = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      DATA,
`ifdef LOADER_CHECKSUM_EN
      CHK,
`endif
      DONE,
      ERR
   } state_t;

   // Merge one stream byte into a partially assembled word.
   function automatic logic [WORD_W-1:0] shift_in(input logic [WORD_W-1:0] word,
                                                  input logic [BYTE_W-1:0] b);
      if (LANE_MSB_FIRST) shift_in = {word[WORD_W-BYTE_W-1:0], b};
      else                shift_in = {b, word[WORD_W-1:BYTE_W]};
   endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects four stream bytes into a 32-bit instruction word and flags completion.
module word_assembler
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              R,
   input  logic              clear,
   input  logic              push,
   input  logic [BYTE_W-1:0] in_data,
   output logic              last_byte_c,
   output logic              word_ready,
   output logic [WORD_W-1:0] word
);

   logic [1:0] byte_idx;

   assign last_byte_c = push && (byte_idx == 2'd3);

   // word holds the completed word in the cycle word_ready is high.
   always_ff @(posedge clk) begin
      if (R) begin
         byte_idx   <= '0;
         word       <= '0;
         word_ready <= 1'b0;
      end else begin
         word_ready <= last_byte_c;
         if (clear) begin
            byte_idx <= '0;
         end else if (push) begin
            byte_idx <= byte_idx + 2'd1;
            word     <= shift_in(word, in_data);
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory, holding the CPU until done.
// Build option: LOADER_CHECKSUM_EN enables the trailing checksum byte check.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W    = ADDR_W_DFLT,
   parameter int unsigned MAX_WORDS = MAX_WORDS_DFLT
) (
   input  logic              clk,
   input  logic              R,
   input  logic              start,
   input  logic              in_valid,
   input  logic [BYTE_W-1:0] in_data,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WORD_W-1:0] wr_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   localparam int unsigned IDX_W = ADDR_W - 2;

   state_t           state;
   logic [IDX_W-1:0] word_idx;
   logic [IDX_W-1:0] last_idx;
   logic             xfer_c;
   logic             clear_c;
   logic             push_c;
   logic             last_byte_c;
   logic             hdr_bad_c;
`ifdef LOADER_CHECKSUM_EN
   logic [BYTE_W-1:0] csum;
`endif

   assign xfer_c    = in_valid && in_ready;
   assign clear_c   = xfer_c && (state == HDR);
   assign push_c    = xfer_c && (state == DATA);
   assign hdr_bad_c = (in_data == '0) || (32'(in_data) > MAX_WORDS);

   word_assembler u_asm (
      .clk         (clk),
      .R           (R),
      .clear       (clear_c),
      .push        (push_c),
      .in_data     (in_data),
      .last_byte_c (last_byte_c),
      .word_ready  (wr_en),
      .word        (wr_data)
   );

   // Load sequencing; done rises the cycle after the final write strobe.
   always_ff @(posedge clk) begin
      if (R) begin
         state    <= IDLE;
         in_ready <= 1'b0;
         wr_addr  <= '0;
         cpu_hold <= 1'b1;
         done     <= 1'b0;
         error    <= 1'b0;
         word_idx <= '0;
         last_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
         csum     <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= HDR;
                  in_ready <= 1'b1;
               end
            end
            HDR: begin
               if (xfer_c) begin
                  if (hdr_bad_c) begin
                     state    <= ERR;
                     in_ready <= 1'b0;
                     error    <= 1'b1;
                  end else begin
                     state    <= DATA;
                     last_idx <= IDX_W'(in_data - 8'd1);
                     word_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
                     csum     <= '0;
`endif
                  end
               end
            end
            DATA: begin
               if (xfer_c) begin
`ifdef LOADER_CHECKSUM_EN
                  csum <= csum ^ in_data;
`endif
                  if (last_byte_c) begin
                     wr_addr  <= {word_idx, 2'b00};
                     word_idx <= word_idx + IDX_W'(1);
                     if (word_idx == last_idx) begin
`ifdef LOADER_CHECKSUM_EN
                        state    <= CHK;
`else
                        state    <= DONE;
                        in_ready <= 1'b0;
`endif
                     end
                  end
               end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
               if (xfer_c) begin
                  in_ready <= 1'b0;
                  if (in_data == csum) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     state <= ERR;
                     error <= 1'b1;
                  end
               end
            end
`endif
            DONE: begin
               if (start) begin
                  state    <= HDR;
                  in_ready <= 1'b1;
                  done     <= 1'b0;
                  cpu_hold <= 1'b1;
               end else begin
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
               end
            end
            ERR: begin
               if (start) begin
                  state    <= HDR;
                  in_ready <= 1'b1;
                  error    <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream instruction-memory loader for the pipelined CPU: accepts a length-prefixed stream of instruction bytes, assembles big-endian 32-bit words, and writes them into the instruction ROM at consecutive word-aligned byte addresses starting at 0. It is the write-side counterpart of the fetch path (PC → ROM → IF_ID). It holds the pipeline in reset until the program image is completely loaded, replacing bench-side file preloading with an in-design load path.

## Interface
- ADDR_W, 8, byte-address width of instruction memory; matches the 8-bit PC.
- MAX_WORDS, 64, largest accepted word count (2^ADDR_W / 4).
- clk  in  1  system clock, rising edge.
- R  in  1  reset: synchronous, active-high.
- start  in  1  one-cycle pulse; begins a load.
- in_valid  in  1  stream byte valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte.
- wr_en  out  1  one-cycle instruction-memory write strobe.
- wr_addr  out  ADDR_W  byte address, always a multiple of 4.
- wr_data  out  32  assembled instruction word.
- cpu_hold  out  1  drives the pipeline reset (PC, IF_ID, ID_EX, EX_MEM, MEM_WB R).
- done  out  1  image loaded and accepted.
- error  out  1  load rejected.

## Operation
- States: IDLE, HDR, DATA, CHK (macro only), DONE, ERR.
- IDLE: start → HDR. In DONE or ERR: start → HDR, clearing done/error and reasserting cpu_hold. In HDR, DATA, and CHK, start is ignored.
- HDR: the accepted byte is the word count N. N=0 or N>MAX_WORDS → ERR. Otherwise latch N, clear the word index and byte index → DATA.
- DATA: bytes arrive MSB first; byte k of a word lands in bits [31-8k -: 8].
- On acceptance of the 4th byte of a word, register a write: wr_data = the word, wr_addr = word_index*4. Then increment word_index.
- After word N-1 is accepted: → CHK if the macro is defined, else → DONE.
- A byte transfers only when in_valid && in_ready. in_ready=1 exactly in HDR, DATA, and CHK, including write cycles, so there are no bubbles.
- cpu_hold = 1 in every state except DONE.
- Partially written memory is never erased: on ERR or on reset, the old contents past the last write remain.

## Timing
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, error=0, state=IDLE, all counters 0.
- start at cycle t → in_ready=1 at t+1.
- 4th byte accepted at cycle t → wr_en=1 at t+1 for exactly one cycle, with wr_addr/wr_data valid in that same cycle.
- Last word written at cycle t (no macro) → at t+1, done=1 and cpu_hold=0.
- Minimum load time with continuous in_valid: 1 + 4N transfer cycles + 1.
- in_valid=0 stalls indefinitely with no timeout. Byte position is preserved across stalls.
- R mid-load: next cycle the block is at reset values and the partial word is discarded.
- R dominates start when both are asserted in the same cycle.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - After the N words, one more byte is accepted in CHK. It must equal the XOR of all 4N payload bytes (the header byte is excluded).
  - Match → DONE on the next cycle.
  - Mismatch → ERR on the next cycle (error=1, cpu_hold stays 1).
  - Words are still written as they arrive.
- Not defined: no CHK state, no checksum register, no trailing byte; the last write leads directly to DONE.

## Structure
- Package imem_loader_pkg: state enumeration, ADDR_W default, MAX_WORDS, and the byte-lane order constant (MSB first).
- Sub-module word_assembler: 2-bit byte index, 32-bit shift register, and word_ready pulse. The FSM, word counter, checksum, and write port stay in imem_loader.

## Test plan
- Load N=2 with payload E3A00005, E2811001, continuous valid:
  - writes (0x00, E3A00005) then (0x04, E2811001);
  - done=1 and cpu_hold=0 one cycle after the second wr_en.
- Same image with in_valid toggled every other cycle → identical writes and done; no bytes are dropped.
- Header 0x00, then header 0x41 in separate runs → ERR with error=1 and cpu_hold=1, zero writes; a later start plus a valid image → done.
- N=64 full load → last write at wr_addr=0xFC; wr_addr never wraps.
- R asserted after 6 payload bytes → reset values next cycle. Reload of N=1 → single write at 0x00 with the new word.
- With LOADER_CHECKSUM_EN, N=1, word 01020304: checksum byte 0x04 → done; byte 0x05 → error, and the write at 0x00 still occurred.
